// File: rtl/inst_fetch.sv
// Fetch stage: drives the instruction memory and buffers {inst, pc} in a 2-entry FIFO for decode.
// Request in N, word on IM_out in N+1, visible to decode in N+2; a credit check stops issue when the FIFO could overflow.
module inst_fetch #(
  parameter int                ADSize   = 16,
  parameter int                DASize   = 32,
  parameter logic [ADSize-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              IM_enable,
  output logic              IM_write,
  output logic [ADSize-1:0] IM_address,
  output logic [DASize-1:0] IM_in,
  input  logic [DASize-1:0] IM_out,
  output logic              inst_valid,
  output logic [DASize-1:0] inst_out,
  output logic [ADSize-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic [ADSize-1:0] br_target
);

  localparam logic [ADSize-1:0] PC_STEP = {{(ADSize-1){1'b0}}, 1'b1};

  logic [ADSize-1:0] r_pc;
  logic [ADSize-1:0] r_req_addr;
  logic              r_pending;
  logic              r_kill;
  logic [1:0]        r_count;
  logic              r_head;
  logic              r_tail;
  logic [DASize-1:0] r_inst [2];
  logic [ADSize-1:0] r_ipc  [2];

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_credit;
  logic [ADSize-1:0] w_addr;

  // A redirect voids any pop in the same cycle so decode never consumes a wrong-path word.
  assign w_pop    = (r_count != 2'd0) && inst_ready && !br_valid;
  assign w_credit = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_issue  = fetch_en && !rst && (br_valid || (w_credit < 3'd2));
  assign w_addr   = br_valid ? br_target : r_pc;
  assign w_push   = r_pending && !r_kill && !br_valid;

  assign IM_enable  = w_issue;
  assign IM_write   = 1'b0;
  assign IM_in      = '0;
  assign IM_address = rst ? RESET_PC : w_addr;

  assign inst_valid = (r_count != 2'd0);
  assign inst_out   = r_inst[r_head];
  assign inst_pc    = r_ipc[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_pending  <= 1'b0;
      r_kill     <= 1'b1;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_inst[i] <= '0;
        r_ipc[i]  <= '0;
      end
    end else begin
      r_pending <= w_issue;
      r_kill    <= 1'b0;

      if (w_issue) begin
        r_pc       <= w_addr + PC_STEP;
        r_req_addr <= w_addr;
      end else if (br_valid) begin
        r_pc <= br_target;
      end

      if (br_valid) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
      end else begin
        if (w_push) begin
          r_inst[r_tail] <= IM_out;
          r_ipc[r_tail]  <= r_req_addr;
          r_tail         <= ~r_tail;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage. It sits directly upstream of the 64Kx32 instruction memory and drives its port with a program counter. It captures each returned word together with its PC in a 2-entry buffer and presents it to decode through a valid/ready handshake. It handles decode backpressure and branch redirects without losing or duplicating instructions.

## Interface
- ADSize, 16: instruction memory address width (word address).
- DASize, 32: instruction width.
- RESET_PC, 16'h0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = issue new fetches; 0 = stop issuing. In-flight data is still captured.
- IM_enable  out  1  memory request strobe.
- IM_write  out  1  tied 0; fetch never writes.
- IM_address  out  ADSize  word address of the request.
- IM_in  out  DASize  tied 0.
- IM_out  in  DASize  memory read data; valid in the cycle after the request.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_out  out  DASize  head instruction.
- inst_pc  out  ADSize  PC of the head instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- br_valid  in  1  redirect request, single-cycle pulse.
- br_target  in  ADSize  redirect word address.

## Operation
- State:
  - pc (ADSize)
  - pending (1 bit): a request was issued last cycle.
  - kill (1 bit): drop the data returning this cycle.
  - 2-entry FIFO of {inst, pc} with count 0..2 and head/tail pointers.
- pop = inst_valid && inst_ready && !br_valid.
- issue = fetch_en && !rst && (br_valid || (count + pending - pop) < 2).
  - The credit check guarantees that every returning word has a free slot. The FIFO never overflows.
- IM_enable = issue. IM_write = 0.
- IM_address = br_valid ? br_target : pc.
- On issue, pc <= IM_address + 1. This is mod 2^ADSize, so 16'hFFFF wraps to 16'h0000.
- pending <= issue. The returned word is tagged with the address of its request, held in a 1-deep address register.
- Capture: if pending && !kill && !br_valid, push {IM_out, req_addr} at the posedge ending the return cycle.
- Redirect (br_valid = 1) in cycle R:
  - FIFO flushed: count <= 0, pointers reset.
  - Any pop in R is void.
  - Data returning in R is dropped.
  - br_target is issued in R if fetch_en = 1. Otherwise pc <= br_target and no issue.
- kill exists for the case where br_valid arrives in the cycle a request is issued without redirect. That cannot happen, because a redirect always replaces the issue. kill is therefore only set by rst, and clears the next cycle.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- Outputs: inst_valid = (count != 0). inst_out and inst_pc come from the head entry and hold stable while inst_valid && !inst_ready.

## Timing
- Reset values:
  - pc = RESET_PC; pending = 0; count = 0; pointers = 0.
  - IM_enable = 0; IM_address = RESET_PC.
  - inst_valid = 0; inst_out = 0; inst_pc = 0.
  - rst has priority over br_valid and fetch_en.
- Latency: request in cycle N → IM_out valid in N+1 → inst_valid with that word in N+2.
- Throughput: 1 instruction/cycle sustained when inst_ready = 1.
- Redirect: br_valid in R → target instruction valid at R+2. No wrong-path instruction is visible from R+1 onward.
- Backpressure: the head stays stable. With inst_ready = 0 the FIFO fills to 2 and issue stops. At most 2 words are buffered and none is lost.
- Reset mid-operation: any in-flight return is discarded (kill). The FIFO is empty in the cycle after rst.
- fetch_en falling: issue stops in the same cycle. The last in-flight word is still buffered.

## Test plan
- Reset, then fetch_en = 1 with inst_ready = 1 and memory preloaded mem[i] = 32'hA000_0000 + i. Expected:
  - IM_address = 0, 1, 2 in cycles 1, 2, 3.
  - inst_valid from cycle 3.
  - inst_out / inst_pc = A0000000/0, A0000001/1, … with no gaps.
- Backpressure: drop inst_ready for 5 cycles mid-stream. Expected:
  - Head holds its value.
  - count saturates at 2 and IM_enable goes 0.
  - On release, instructions resume in PC order with no skips or duplicates.
- Redirect: br_valid for 1 cycle with br_target = 16'h0100 while the FIFO is full. Expected:
  - inst_valid = 0 at R+1.
  - At R+2, inst_pc = 16'h0100 and inst_out = A0000100.
  - Then 0x0101, 0x0102, and so on.
- Wrap-around: RESET_PC = 16'hFFFE. Expected: fetch order is FFFE, FFFF, 0000, 0001.
- fetch_en low for 3 cycles mid-stream. Expected:
  - IM_enable = 0 in those cycles.
  - The in-flight word is still delivered.
  - Fetch resumes at the next sequential PC.
- rst asserted for 1 cycle with 2 buffered words and 1 in flight. Expected:
  - Next cycle: inst_valid = 0 and pc = RESET_PC.
  - The stale in-flight word never appears.
  - The first post-reset instruction has inst_pc = RESET_PC.
